// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial add sequencer: state encoding,
// default operand width and bit-counter width.
package serial_add_pkg;

    localparam int DEFAULT_N = 4;
    localparam int CNT_W     = $clog2(DEFAULT_N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    // Counter width for an arbitrary operand width; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_operand_reg.sv
// N-bit parallel-load, shift-right register; bit 0 is the serial output,
// so operands leave LSB first.
module piso_operand_reg #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] par_i,
    output logic         ser_o
);

    logic [N-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= par_i;
        end else if (shift_i) begin
            data_q <= {1'b0, data_q[N-1:1]};
        end
    end

    assign ser_o = data_q[0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Sequencer for a downstream serial adder: streams two captured operands out
// LSB first (LOAD), then runs N add shifts (ADD). Optional sum capture: SEQ_SUM_CAPTURE_EN.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         sum_in,
    output logic         shift_cont,
    output logic         ser_a,
    output logic         ser_b,
    output logic         add_sel,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum_out,
    output logic [1:0]   dbg_state_o
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    seq_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          shift_cont_q;
    logic          add_sel_q;
    logic          busy_q;
    logic          done_q;
    logic          load_q;
    logic          accept;
    logic          a_bit;
    logic          b_bit;

    assign accept = (state_q == S_IDLE) && start;

    piso_operand_reg #(.N(N)) u_reg_a (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (accept),
        .shift_i (state_q == S_LOAD),
        .par_i   (op_a),
        .ser_o   (a_bit)
    );

    piso_operand_reg #(.N(N)) u_reg_b (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (accept),
        .shift_i (state_q == S_LOAD),
        .par_i   (op_b),
        .ser_o   (b_bit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_cont_q <= 1'b0;
            add_sel_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        cnt_q        <= '0;
                        shift_cont_q <= 1'b1;
                        add_sel_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        load_q       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q   <= S_ADD;
                        cnt_q     <= '0;
                        add_sel_q <= 1'b1;
                        load_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ADD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q      <= S_DONE;
                        cnt_q        <= '0;
                        shift_cont_q <= 1'b0;
                        add_sel_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Serial bits are only driven while streaming; the registers drain to 0 afterwards anyway.
    assign ser_a       = load_q & a_bit;
    assign ser_b       = load_q & b_bit;
    assign shift_cont  = shift_cont_q;
    assign add_sel     = add_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

`ifdef SEQ_SUM_CAPTURE_EN
    logic [N-1:0] sum_q;

    // Shift in at the MSB so the first returned sum bit ends up in bit 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state_q == S_ADD) begin
            sum_q <= {sum_in, sum_q[N-1:1]};
        end
    end

    assign sum_out = sum_q;
`else
    logic unused_sum_in;
    assign unused_sum_in = sum_in;
    assign sum_out       = '0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: cycle-schedule reference model,
// per-cycle compare, directed literal runs and randomized traffic.
module tb_serial_add_sequencer;
    import serial_add_pkg::*;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;
    logic         sum_in = 1'b0;
    logic         shift_cont;
    logic         ser_a;
    logic         ser_b;
    logic         add_sel;
    logic         busy;
    logic         done;
    logic [N-1:0] sum_out;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // expected {shift_cont, add_sel, ser_a, ser_b, busy, done} per cycle of a directed run
    logic [5:0] exp_q[$];

    serial_add_sequencer #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .sum_in      (sum_in),
        .shift_cont  (shift_cont),
        .ser_a       (ser_a),
        .ser_b       (ser_b),
        .add_sel     (add_sel),
        .busy        (busy),
        .done        (done),
        .sum_out     (sum_out),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pos = cycle index since acceptance: 0 idle, 1..N load, N+1..2N add, 2N+1 done.
    int           pos = 0;
    logic [N-1:0] cap_a = '0;
    logic [N-1:0] cap_b = '0;
    logic [N-1:0] sum_m = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos   = 0;
            cap_a = '0;
            cap_b = '0;
            sum_m = '0;
        end else if (pos == 0) begin
            if (start === 1'b1) begin
                cap_a = op_a;
                cap_b = op_b;
                sum_m = '0;
                pos   = 1;
            end
        end else begin
            if (pos > N && pos <= 2 * N) sum_m[pos-N-1] = sum_in;
            pos = (pos == 2 * N + 1) ? 0 : pos + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic         e_load, e_add;
        logic [1:0]   e_state;
        logic [N-1:0] e_sum;
        e_load  = (pos >= 1 && pos <= N);
        e_add   = (pos > N && pos <= 2 * N);
        e_state = (pos == 0) ? S_IDLE : e_load ? S_LOAD : e_add ? S_ADD : S_DONE;
        check("m_shift_cont", 32'(shift_cont), 32'(e_load | e_add));
        check("m_add_sel", 32'(add_sel), 32'(e_add));
        check("m_busy", 32'(busy), 32'(e_load | e_add));
        check("m_done", 32'(done), 32'(pos == 2 * N + 1));
        check("m_ser_a", 32'(ser_a), 32'(e_load ? cap_a[pos-1] : 1'b0));
        check("m_ser_b", 32'(ser_b), 32'(e_load ? cap_b[pos-1] : 1'b0));
        check("m_state", 32'(dbg_state), 32'(e_state));
        if (pos == 0 || pos == 2 * N + 1) begin
`ifdef SEQ_SUM_CAPTURE_EN
            e_sum = sum_m;
`else
            e_sum = '0;
`endif
            check("m_sum_out", 32'(sum_out), 32'(e_sum));
        end
    end

    // ---------------- driver tasks ----------------
    // One operation with op_a=0011, op_b=0101 and sum_in 0,0,0,1 over the ADD cycles.
    task automatic run_directed(input bit scramble_ops);
        logic [N-1:0] pat;
        logic [N-1:0] exp_sum;
        logic [5:0]   got;
        int           sc_cnt;
        pat    = 4'b1000;
        sc_cnt = 0;
`ifdef SEQ_SUM_CAPTURE_EN
        exp_sum = 4'b1000;
`else
        exp_sum = 4'b0000;
`endif
        exp_q = {6'b101110, 6'b101010, 6'b100110, 6'b100010,
                 6'b110010, 6'b110010, 6'b110010, 6'b110010,
                 6'b000001, 6'b000000};
        @(negedge clock);
        start  = 1'b1;
        op_a   = 4'b0011;
        op_b   = 4'b0101;
        sum_in = 1'b0;
        for (int c = 1; c <= 2 * N + 2; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start = 1'b0;
                if (scramble_ops) begin
                    op_a = 4'b1111;
                    op_b = 4'b1111;
                end
            end
            got = {shift_cont, add_sel, ser_a, ser_b, busy, done};
            if (shift_cont) sc_cnt++;
            check($sformatf("d_vec_c%0d", c), 32'(got), 32'(exp_q.pop_front()));
            if (c == 2 * N + 1) check("d_sum_at_done", 32'(sum_out), 32'(exp_sum));
            sum_in = (c > N && c <= 2 * N) ? pat[c-N-1] : 1'b0;
        end
        check("d_shift_cycles", 32'(sc_cnt), 32'd8);
        check("d_sum_hold_idle", 32'(sum_out), 32'(exp_sum));
    endtask

    task automatic run_start_held();
        int dones;
        dones = 0;
        @(negedge clock);
        start = 1'b1;
        op_a  = 4'b1010;
        op_b  = 4'b0110;
        repeat (2 * (2 * N + 2)) begin
            @(negedge clock);
            if (done) dones++;
        end
        start = 1'b0;
        check("h_done_count", 32'(dones), 32'd2);
        repeat (2 * N + 3) @(negedge clock);
        check("h_idle_after", 32'(dbg_state), 32'(S_IDLE));
    endtask

    task automatic run_reset_mid_add();
        int dones;
        dones = 0;
        @(negedge clock);
        start = 1'b1;
        op_a  = 4'b1001;
        op_b  = 4'b0110;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("r_in_add", 32'(add_sel), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("r_async_outs", 32'({shift_cont, add_sel, ser_a, ser_b, busy, done}), 32'd0);
        check("r_async_state", 32'(dbg_state), 32'(S_IDLE));
        check("r_async_sum", 32'(sum_out), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (12) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("r_no_done", 32'(dones), 32'd0);
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            start  = ($urandom_range(0, 3) == 0);
            op_a   = N'($urandom);
            op_b   = N'($urandom);
            sum_in = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        repeat (2 * N + 3) @(negedge clock);
    endtask

    // ---------------- reset and sequence ----------------
    initial begin
        #2;
        check("rst_outs", 32'({shift_cont, add_sel, ser_a, ser_b, busy, done}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_sum", 32'(sum_out), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_directed(1'b0);
        run_directed(1'b1);
        run_start_held();
        run_reset_mid_add();
        run_directed(1'b0);
        run_random(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
